// File: rtl/fabric_tag_arbiter.sv
// Round-robin arbiter merging NUM_IN untagged streams into one registered,
// tagged output stream; each word carries the index of the input it came from.
module fabric_tag_arbiter #(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_IN-1:0]               cfg_in_mask,
  input  logic [NUM_IN-1:0]               in_valid,
  output logic [NUM_IN-1:0]               in_ready,
  input  logic [NUM_IN*DATA_WIDTH-1:0]    in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH+TAG_WIDTH-1:0] out_data
);

  localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int OUT_W = DATA_WIDTH + TAG_WIDTH;

  if ((NUM_IN < 2) || (NUM_IN > 16)) begin : g_bad_num_in
    $fatal(1, "COMP_TAG_ARB_NUM_IN: NUM_IN=%0d outside 2..16", NUM_IN);
  end
  if (DATA_WIDTH < 1) begin : g_bad_data_width
    $fatal(1, "COMP_TAG_ARB_DATA_WIDTH: DATA_WIDTH=%0d must be >= 1", DATA_WIDTH);
  end
  if (TAG_WIDTH < PTR_W) begin : g_bad_tag_width
    $fatal(1, "COMP_TAG_ARB_TAG_WIDTH: TAG_WIDTH=%0d too narrow for NUM_IN=%0d", TAG_WIDTH, NUM_IN);
  end

  logic                  out_valid_r;
  logic [OUT_W-1:0]      out_data_r;
  logic [PTR_W-1:0]      rr_ptr_r;
  logic [NUM_IN-1:0]     elig_s;
  logic                  load_ok_s;
  logic                  found_s;
  logic                  grant_s;
  logic [PTR_W-1:0]      win_idx_s;

  // Index arithmetic modulo NUM_IN, used for the search order and pointer advance.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
    int sum_v;
    sum_v = int'(base) + off;
    if (sum_v >= NUM_IN) begin
      sum_v = sum_v - NUM_IN;
    end else begin
      sum_v = sum_v;
    end
    return PTR_W'(sum_v);
  endfunction

  assign elig_s    = in_valid & cfg_in_mask;
  assign load_ok_s = !out_valid_r || out_ready;

  // Round-robin search; walking offsets downward lets the closest eligible input win.
  always_comb begin
    found_s   = 1'b0;
    win_idx_s = {PTR_W{1'b0}};
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      found_s   = found_s | elig_s[wrap_add(rr_ptr_r, k)];
      win_idx_s = elig_s[wrap_add(rr_ptr_r, k)] ? wrap_add(rr_ptr_r, k) : win_idx_s;
    end
  end

  assign grant_s = load_ok_s && found_s && !rst_n;

  // One-hot ready toward the winning requester, held at zero during reset.
  always_comb begin
    in_ready = {NUM_IN{1'b0}};
    if (grant_s) begin
      in_ready = NUM_IN'(1'b1) << win_idx_s;
    end else begin
      in_ready = {NUM_IN{1'b0}};
    end
  end

  // Output register and round-robin pointer; a grant may replace a word draining this edge.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {OUT_W{1'b0}};
      rr_ptr_r    <= {PTR_W{1'b0}};
    end else if (grant_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= {TAG_WIDTH'(win_idx_s), in_data[int'(win_idx_s)*DATA_WIDTH +: DATA_WIDTH]};
      rr_ptr_r    <= wrap_add(win_idx_s, 1);
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

endmodule

// File: doc/fabric_tag_arbiter.md
FABRIC_TAG_ARBITER -- requirements
Module: fabric_tag_arbiter

Interface
REQ-001 Parameter NUM_IN, default 4: number of untagged requester streams; legal 2..16.
REQ-002 Parameter DATA_WIDTH, default 32: value width per stream; legal >= 1.
REQ-003 Parameter TAG_WIDTH, default 4: width of the appended tag; legal >= $clog2(NUM_IN).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-high (asserted when 1), sampled on the rising edge of clk.
REQ-006 cfg_in_mask  input  NUM_IN  per-input enable; bit i = 1 allows input i to be granted.
REQ-007 in_valid  input  NUM_IN  per-input valid.
REQ-008 in_ready  output  NUM_IN  per-input ready (one-hot or zero).
REQ-009 in_data  input  NUM_IN*DATA_WIDTH  input i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 out_valid  output  1  tagged output valid.
REQ-011 out_ready  input  1  downstream ready.
REQ-012 out_data  output  DATA_WIDTH+TAG_WIDTH  value in [DATA_WIDTH-1:0], tag in [DATA_WIDTH+TAG_WIDTH-1:DATA_WIDTH].

Function
REQ-013 Illegal NUM_IN, DATA_WIDTH or TAG_WIDTH SHALL trigger $fatal at elaboration with codes COMP_TAG_ARB_NUM_IN, COMP_TAG_ARB_DATA_WIDTH, COMP_TAG_ARB_TAG_WIDTH.
REQ-014 The block SHALL hold one output register (out_valid, out_data); out_valid/out_data SHALL be driven only from this register.
REQ-015 load_ok SHALL be (!out_valid) | out_ready (register empty or draining this cycle).
REQ-016 Eligible set SHALL be in_valid & cfg_in_mask; inputs with mask bit 0 SHALL never see in_ready = 1.
REQ-017 Arbitration SHALL be round-robin: search starts at rr_ptr, ascending index with wrap NUM_IN-1 -> 0; first eligible input wins.
REQ-018 in_ready[i] SHALL be 1 only if load_ok and i is the winner; at most one in_ready bit high per cycle.
REQ-019 On a grant to i: output register loads {i zero-extended to TAG_WIDTH, in_data slice i}, out_valid = 1 next cycle; rr_ptr = (i+1) mod NUM_IN.
REQ-020 If out_valid & out_ready and no grant: out_valid SHALL clear next cycle.
REQ-021 If out_valid & !out_ready: register, out_data and rr_ptr SHALL hold; all in_ready = 0.
REQ-022 Simultaneous drain and grant SHALL replace the register contents in the same edge (full throughput: one transfer per cycle sustained).
REQ-023 Latency SHALL be exactly 1 cycle from input handshake to out_valid.
REQ-024 No eligible input: rr_ptr SHALL hold.
REQ-025 in_ready SHALL be combinational on in_valid, cfg_in_mask, out_ready and state; out_valid SHALL NOT depend combinationally on any input.
REQ-026 cfg_in_mask changes take effect the same cycle; a word already in the output register SHALL still be delivered.
REQ-027 Tag values >= NUM_IN SHALL never be emitted.

Reset
REQ-028 While rst_n = 1 at a clock edge: out_valid = 0, out_data = 0, rr_ptr = 0 after that edge.
REQ-029 While rst_n = 1, in_ready SHALL be all-zero combinationally; reset mid-transfer discards the buffered word without delivering it.
REQ-030 First cycle after reset deassertion SHALL permit a grant (rr_ptr = 0 priority).

Verification
REQ-031 NUM_IN=4, mask=4'hF, all valid, out_ready=1 continuously -> tags 0,1,2,3,0,... one per cycle from cycle 1.
REQ-032 Only input 2 valid with data 0xDEADBEEF, out_ready=1 -> out_data = {4'h2, 32'hDEADBEEF} one cycle later; rr_ptr = 3.
REQ-033 Output full, out_ready=0 for 5 cycles with all inputs valid -> out_data stable, all in_ready = 0; on out_ready=1 next winner loads same edge.
REQ-034 mask=4'b1010, all valid -> only tags 1 and 3 alternate; in_ready[0], in_ready[2] never 1.
REQ-035 rst_n=1 asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_data=0, first post-reset grant goes to lowest eligible index.
REQ-036 Random valid/ready/mask stress with scoreboard -> every accepted word emitted exactly once, in order, correct tag; no input starved beyond NUM_IN-1 grants while eligible.
